servant_mem_arbiter: RTL

SERVANT_MEM_ARBITER -- requirements
Module: servant_mem_arbiter

---
 rtl/servant_arb_pkg.sv | 18 +
 rtl/servant_arb_rr.sv | 28 ++
 rtl/servant_mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/servant_arb_pkg.sv
// Shared types and constants for the servant shared-RAM arbiter.
package servant_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    localparam logic [1:0] MST_NONE = 2'd0;
    localparam logic [1:0] MST_M0   = 2'd1;
    localparam logic [1:0] MST_M1   = 2'd2;
    localparam logic [1:0] MST_M2   = 2'd3;

    localparam int unsigned DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/servant_arb_rr.sv
// Two-way round-robin picker for the CPU masters (bit 0 = M0, bit 1 = M1).
module servant_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Set when M1 was the last CPU master served; reset leaves M1 preferred.
    logic last_m1;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_m1 ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_m1 <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            last_m1 <= gnt[1];
        end
    end

endmodule

// File: rtl/servant_mem_arbiter.sv
// Three-master arbiter in front of the servant shared RAM: debug master has strict
// priority and an exclusive lock, CPU masters share round-robin, stalled transfers time out.
module servant_mem_arbiter
    import servant_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic        wb_clk,
    input  logic        wb_rstn,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    input  logic [31:0] i_dm_adr,
    input  logic [31:0] i_dm_dat,
    input  logic [3:0]  i_dm_sel,
    input  logic        i_dm_we,
    input  logic        i_dm_cyc,
    output logic [31:0] o_dm_rdt,
    output logic        o_dm_ack,
    input  logic        i_dm_lock,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    output logic [3:0]  o_mem_sel,
    output logic        o_mem_we,
    output logic        o_mem_cyc,
    input  logic [31:0] i_mem_rdt,
    input  logic        i_mem_ack,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [1:0]    owner;
    logic [CW-1:0] to_cnt;
    logic [1:0]    rr_req;
    logic [1:0]    rr_gnt;
    logic          rr_advance;
    logic [1:0]    winner;
    logic          owner_cyc;
    logic          mem_done;
    logic          to_fire;
    logic          owner_ack;
    logic [31:0]   rdt_route;

    assign rr_req = {i_dbus_cyc, i_ibus_cyc} & {2{~i_dm_lock}};

    servant_arb_rr u_rr (
        .clk     (wb_clk),
        .rst_n   (wb_rstn),
        .req     (rr_req),
        .advance (rr_advance),
        .gnt     (rr_gnt)
    );

    always_comb begin
        winner = MST_NONE;
        if (i_dm_cyc) begin
            winner = MST_M2;
        end else if (rr_gnt[1]) begin
            winner = MST_M1;
        end else if (rr_gnt[0]) begin
            winner = MST_M0;
        end
    end

    always_comb begin
        case (owner)
            MST_M0:  owner_cyc = i_ibus_cyc;
            MST_M1:  owner_cyc = i_dbus_cyc;
            MST_M2:  owner_cyc = i_dm_cyc;
            default: owner_cyc = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A dropped cyc takes precedence over ack/timeout: the master is gone, nobody is acked.
    always_comb begin
        state_nxt  = state;
        rr_advance = 1'b0;
        mem_done   = 1'b0;
        to_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (winner != MST_NONE) begin
                    state_nxt  = ST_GRANT;
                    rr_advance = (winner != MST_M2);
                end
            end
            ST_GRANT: begin
                if (!owner_cyc) begin
                    state_nxt = ST_DRAIN;
                end else if (i_mem_ack) begin
                    mem_done  = 1'b1;
                    state_nxt = ST_DRAIN;
                end else if (to_cnt == TO_LAST) begin
                    to_fire   = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rstn) begin
        if (!wb_rstn) begin
            owner     <= MST_NONE;
            to_cnt    <= '0;
            o_mem_adr <= '0;
            o_mem_dat <= '0;
            o_mem_sel <= '0;
            o_mem_we  <= 1'b0;
            o_mem_cyc <= 1'b0;
        end else if ((state == ST_IDLE) && (winner != MST_NONE)) begin
            owner     <= winner;
            to_cnt    <= '0;
            o_mem_cyc <= 1'b1;
            case (winner)
                MST_M0: begin
                    o_mem_adr <= i_ibus_adr;
                    o_mem_dat <= '0;
                    o_mem_sel <= 4'hF;
                    o_mem_we  <= 1'b0;
                end
                MST_M1: begin
                    o_mem_adr <= i_dbus_adr;
                    o_mem_dat <= i_dbus_dat;
                    o_mem_sel <= i_dbus_sel;
                    o_mem_we  <= i_dbus_we;
                end
                default: begin
                    o_mem_adr <= i_dm_adr;
                    o_mem_dat <= i_dm_dat;
                    o_mem_sel <= i_dm_sel;
                    o_mem_we  <= i_dm_we;
                end
            endcase
        end else if (state == ST_GRANT) begin
            if (state_nxt == ST_DRAIN) begin
                owner     <= MST_NONE;
                o_mem_adr <= '0;
                o_mem_dat <= '0;
                o_mem_sel <= '0;
                o_mem_we  <= 1'b0;
                o_mem_cyc <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign o_grant   = owner;
    assign o_timeout = to_fire;
    assign owner_ack = mem_done | to_fire;
    assign rdt_route = to_fire ? ERR_DATA : i_mem_rdt;

    always_comb begin
        o_ibus_rdt = '0;
        o_ibus_ack = 1'b0;
        o_dbus_rdt = '0;
        o_dbus_ack = 1'b0;
        o_dm_rdt   = '0;
        o_dm_ack   = 1'b0;
        if (state == ST_GRANT) begin
            case (owner)
                MST_M0: begin
                    o_ibus_rdt = rdt_route;
                    o_ibus_ack = owner_ack;
                end
                MST_M1: begin
                    o_dbus_rdt = rdt_route;
                    o_dbus_ack = owner_ack;
                end
                MST_M2: begin
                    o_dm_rdt = rdt_route;
                    o_dm_ack = owner_ack;
                end
                default: ;
            endcase
        end
    end

endmodule
